// File: rtl/status_uart_tx_pkg.sv
// Shared constants, UART state encoding and line formatting
// for the status line transmitter.
package status_uart_tx_pkg;

  localparam logic [7:0] CH_T    = 8'h54;
  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_EQ   = 8'h3D;
  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_STAR = 8'h2A;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;

  localparam int FRAME_LEN = 11;
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_t;

  typedef struct packed {
    logic [7:0] tm;
    logic [7:0] tl;
    logic [7:0] sm;
    logic [7:0] sl;
    logic       done;
  } snap_t;

  function automatic logic [7:0] line_byte(
    input logic [3:0] idx,
    input snap_t      s
  );
    logic [7:0] b;
    case (idx)
      4'd0:    b = CH_T;
      4'd1:    b = CH_EQ;
      4'd2:    b = s.tm;
      4'd3:    b = s.tl;
      4'd4:    b = s.done ? CH_STAR : CH_SP;
      4'd5:    b = CH_S;
      4'd6:    b = CH_EQ;
      4'd7:    b = s.sm;
      4'd8:    b = s.sl;
      4'd9:    b = CH_CR;
      default: b = CH_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/status_uart_tx_if.sv
// Status-port bundle between the game logic and the UART
// status transmitter.
interface status_uart_tx_if;

  logic [7:0] time_MSB_ascii;
  logic [7:0] time_LSB_ascii;
  logic [7:0] score_MSB_ascii;
  logic [7:0] score_LSB_ascii;
  logic       timer_done;
  logic       send_req;
  logic       tx;
  logic       busy;
  logic       frame_done;

  modport master (
    output time_MSB_ascii,
    output time_LSB_ascii,
    output score_MSB_ascii,
    output score_LSB_ascii,
    output timer_done,
    output send_req,
    input  tx,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  time_MSB_ascii,
    input  time_LSB_ascii,
    input  score_MSB_ascii,
    input  score_LSB_ascii,
    input  timer_done,
    input  send_req,
    output tx,
    output busy,
    output frame_done
  );

endinterface

// File: rtl/status_uart_tx_byte.sv
// 8N1 byte serializer; ready rises on the last stop-bit cycle
// so the next byte follows with no idle gap.
module status_uart_tx_byte
  import status_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(CLKS_PER_BIT - 1);

  uart_state_t   state;
  uart_state_t   state_n;
  logic [CW-1:0] baud_cnt;
  logic [CW-1:0] baud_cnt_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_n;
  logic [7:0]    shreg;
  logic [7:0]    shreg_n;
  logic          bit_end;

  always_comb begin
    bit_end    = (baud_cnt == CNT_LAST);
    state_n    = state;
    baud_cnt_n = bit_end ? '0 : baud_cnt + CW'(1);
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    ready      = 1'b0;
    tx         = 1'b1;
    unique case (state)
      ST_IDLE: begin
        ready      = 1'b1;
        baud_cnt_n = '0;
      end
      ST_START: begin
        tx = 1'b0;
        if (bit_end) begin
          state_n   = ST_DATA;
          bit_idx_n = '0;
        end
      end
      ST_DATA: begin
        tx = shreg[0];
        if (bit_end) begin
          shreg_n   = shreg >> 1;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7)
            state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        ready = bit_end;
        if (bit_end)
          state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    // Loading overrides the idle/stop exit so bytes chain back to back.
    if (ready && valid) begin
      state_n    = ST_START;
      shreg_n    = data;
      baud_cnt_n = '0;
      bit_idx_n  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
    end
  end

endmodule

// File: rtl/status_uart_tx.sv
// Snapshots the game status and streams it as one 11-byte
// text line over UART 8N1, with a one-deep request queue.
module status_uart_tx
  import status_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input logic       clk,
  input logic       rst_n,
  status_uart_tx_if.slave bus
);

  snap_t      snap;
  logic       busy_q;
  logic       pending;
  logic [3:0] char_idx;
  logic [3:0] next_idx;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       fire;
  logic       frame_end;

  // Byte 0 is a constant, so it can go out on the accept edge
  // before the snapshot register has loaded.
  always_comb begin
    next_idx   = busy_q ? char_idx + 4'd1 : 4'd0;
    byte_valid = busy_q ? (char_idx < LAST_IDX)
                        : (bus.send_req | pending);
    byte_data  = line_byte(next_idx, snap);
    fire       = byte_valid & byte_ready;
    frame_end  = busy_q & (char_idx == LAST_IDX)
               & byte_ready;
  end

  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      pending  <= 1'b0;
      char_idx <= '0;
      snap     <= '0;
    end else if (!busy_q) begin
      if (fire) begin
        snap <= {bus.time_MSB_ascii,
                 bus.time_LSB_ascii,
                 bus.score_MSB_ascii,
                 bus.score_LSB_ascii,
                 bus.timer_done};
        busy_q   <= 1'b1;
        pending  <= 1'b0;
        char_idx <= '0;
      end
    end else begin
      if (bus.send_req)
        pending <= 1'b1;
      if (fire)
        char_idx <= char_idx + 4'd1;
      if (frame_end)
        busy_q <= 1'b0;
    end
  end

  status_uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk  (clk),
    .rst_n(rst_n),
    .valid(byte_valid),
    .data (byte_data),
    .ready(byte_ready),
    .tx   (bus.tx)
  );

endmodule

// File: tb/tb_status_uart_tx.sv
// Directed and randomized checks of the status line transmitter
// against a line-level model of the expected serial waveform.
module tb_status_uart_tx;

  localparam int C    = 4;
  localparam int LINE = 110 * C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  status_uart_tx_if bus();

  status_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  bit log_tx[$];
  bit log_busy[$];
  bit log_fd[$];
  int passed = 0;
  int total  = 0;

  logic [7:0] cur_tm, cur_tl, cur_sm, cur_sl;
  logic       cur_done;

  task automatic step();
    @(posedge clk);
    #1;
    log_tx.push_back(bus.tx);
    log_busy.push_back(bus.busy);
    log_fd.push_back(bus.frame_done);
  endtask

  task automatic run_to(input int n);
    while (log_tx.size() < n) step();
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic set_in(input logic [7:0] tm, input logic [7:0] tl,
                        input logic [7:0] sm, input logic [7:0] sl,
                        input logic done);
    cur_tm = tm; cur_tl = tl; cur_sm = sm; cur_sl = sl;
    cur_done = done;
    bus.time_MSB_ascii  = tm;
    bus.time_LSB_ascii  = tl;
    bus.score_MSB_ascii = sm;
    bus.score_LSB_ascii = sl;
    bus.timer_done      = done;
  endtask

  function automatic logic [7:0] rnd_char();
    if ($urandom_range(0, 3) == 0)
      return 8'($urandom_range(0, 255));
    return 8'h30 + 8'($urandom_range(0, 9));
  endfunction

  task automatic set_rand();
    set_in(rnd_char(), rnd_char(), rnd_char(), rnd_char(),
           1'($urandom_range(0, 1)));
  endtask

  function automatic logic [87:0] model_line();
    return {8'h54, 8'h3D, cur_tm, cur_tl,
            cur_done ? 8'h2A : 8'h20,
            8'h53, 8'h3D, cur_sm, cur_sl, 8'h0D, 8'h0A};
  endfunction

  // Request pulse whose accept edge starts log index s.
  task automatic pulse(output int s);
    s = log_tx.size();
    bus.send_req = 1'b1;
    step();
    bus.send_req = 1'b0;
  endtask

  task automatic check_line(input int s, input logic [87:0] line,
                            input string tag);
    int bad, fds, bp, k, bi;
    logic [7:0] b, e;
    logic x;
    run_to(s + LINE + 1);
    for (int kk = 0; kk < 11; kk++) begin
      e = line[87-8*kk -: 8];
      for (int i = 0; i < 8; i++)
        b[i] = log_tx[s + (kk*10 + 1 + i)*C + C/2];
      check($sformatf("%s_byte%0d", tag, kk), 32'(b), 32'(e));
    end
    bad = 0;
    fds = 0;
    for (int c = 0; c <= LINE; c++) begin
      if (log_fd[s+c]) fds++;
      if (c < LINE) begin
        bp = c / C;
        k  = bp / 10;
        bi = bp % 10;
        e  = line[87-8*k -: 8];
        x  = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : e[bi-1];
        if (log_tx[s+c] !== x || log_busy[s+c] !== 1'b1) bad++;
      end
    end
    check({tag, "_wave"}, 32'(bad), 0);
    check({tag, "_fd_count"}, 32'(fds), 1);
    check({tag, "_fd_last"}, 32'(log_fd[s+LINE-1]), 1);
    check({tag, "_busy_end"}, 32'(log_busy[s+LINE]), 0);
    check({tag, "_busy_pre"}, 32'(log_busy[s-1]), 0);
  endtask

  task automatic check_quiet(input int from, input int n,
                             input string tag);
    int bad;
    run_to(from + n);
    bad = 0;
    for (int c = from; c < from + n; c++)
      if (!log_tx[c] || log_busy[c] || log_fd[c]) bad++;
    check(tag, 32'(bad), 0);
  endtask

  initial begin
    int s, s2, idx, fds;
    logic [87:0] l1, l2;
    bus.send_req = 1'b0;
    set_in(8'h30, 8'h30, 8'h30, 8'h30, 1'b0);

    // 1: reset
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_tx", 32'(bus.tx), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_fd", 32'(bus.frame_done), 0);
    check_quiet(log_tx.size(), 20, "rst_idle");

    // 2: basic line
    set_in("3", "1", "0", "5", 1'b0);
    pulse(s);
    check("t2_model", 32'(model_line() == 88'h543D333120533D30350D0A),
          1);
    check_line(s, model_line(), "t2");

    // 3: snapshot isolation
    set_in("3", "1", "0", "5", 1'b0);
    pulse(s);
    l1 = model_line();
    run_to(s + 20);
    set_in("3", "0", "9", "9", 1'b1);
    check_line(s, l1, "t3a");
    pulse(s);
    check_line(s, model_line(), "t3b");

    // 4: three requests during one line -> two lines
    set_rand();
    pulse(s);
    l1 = model_line();
    run_to(s + 10);
    set_rand();
    l2 = model_line();
    run_to(s + 50);  pulse(idx);
    run_to(s + 100); pulse(idx);
    run_to(s + 300); pulse(idx);
    check_line(s, l1, "t4a");
    s2 = s + LINE + 1;
    check_line(s2, l2, "t4b");
    check_quiet(s2 + LINE, 60, "t4_no_third");

    // 5: timer_done separator
    set_in("0", "0", "1", "2", 1'b1);
    pulse(s);
    check_line(s, 88'h543D30302A533D31320D0A, "t5");

    // randomized single lines with mid-line input churn
    for (int n = 0; n < 3; n++) begin
      set_rand();
      pulse(s);
      l1 = model_line();
      run_to(s + $urandom_range(2, LINE - 2));
      set_rand();
      check_line(s, l1, $sformatf("rnd%0d", n));
    end

    // send_req held high: back-to-back lines
    set_rand();
    s = log_tx.size();
    bus.send_req = 1'b1;
    l1 = model_line();
    run_to(s + 10);
    set_rand();
    l2 = model_line();
    s2 = s + LINE + 1;
    run_to(s2 + 1);
    bus.send_req = 1'b0;
    check_line(s, l1, "held_a");
    check_line(s2, l2, "held_b");
    check_quiet(s2 + LINE, 40, "held_stop");

    // 6: reset during a data bit of byte 3
    set_rand();
    pulse(s);
    idx = s + (3*10 + 2)*C + 1;
    run_to(idx + 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_tx_async", 32'(bus.tx), 1);
    check("t6_busy_async", 32'(bus.busy), 0);
    check("t6_fd_async", 32'(bus.frame_done), 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    fds = 0;
    for (int c = s; c < log_fd.size(); c++)
      if (log_fd[c]) fds++;
    check("t6_no_fd", 32'(fds), 0);
    check_quiet(log_tx.size(), 10, "t6_idle");
    set_rand();
    pulse(s);
    check_line(s, model_line(), "t6_after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
